// File: rtl/wb_pkg.sv
// Writeback sequencer shared definitions: op encodings, FSM states,
// writeback mux select constants and the JAL link register index.
package wb_pkg;

  localparam logic [2:0] OP_ALU  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_MFHI = 3'd2;
  localparam logic [2:0] OP_MFLO = 3'd3;
  localparam logic [2:0] OP_JAL  = 3'd4;

  // Select order is {sel_jump, sel_hilo, sel_memtoreg}.
  localparam logic [2:0] SEL_ALU  = 3'b000;
  localparam logic [2:0] SEL_LOAD = 3'b001;
  localparam logic [2:0] SEL_MFHI = 3'b010;
  localparam logic [2:0] SEL_MFLO = 3'b011;
  localparam logic [2:0] SEL_JAL  = 3'b100;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WAIT_HILO,
    WRITE
  } wb_state_e;

endpackage

// File: rtl/wb_sequencer.sv
// Writeback sequencer: accepts one writeback request at a time from decode,
// waits for load data or a busy HI/LO unit as needed, then issues a single
// register-file write with the matching writeback mux selects.
//   clk, rst_n            clock, async active-low reset
//   wb_valid/wb_ready     request handshake (ready only in IDLE)
//   wb_op, wb_rd          op class and destination register
//   mem_valid             load data valid
//   hilo_busy             HI/LO still being updated
//   sel_*                 writeback mux selects (registered)
//   reg_write, reg_waddr  register-file write port (registered)
//   wb_err                one-cycle pulse on illegal op or load timeout
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wb_valid,
  output logic       wb_ready,
  input  logic [2:0] wb_op,
  input  logic [4:0] wb_rd,
  input  logic       mem_valid,
  input  logic       hilo_busy,
  output logic       sel_memtoreg,
  output logic       sel_hilo,
  output logic       sel_jump,
  output logic       reg_write,
  output logic [4:0] reg_waddr,
  output logic       wb_err
);

  localparam logic [3:0] TIMEOUT_CNT = 4'(MEM_TIMEOUT);

  wb_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;
  logic [2:0] sel_q, sel_d;
  logic [4:0] waddr_q, waddr_d;
  logic       reg_write_q, reg_write_d;
  logic       wb_err_q, wb_err_d;
  logic       wb_ready_q, wb_ready_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= SEL_ALU;
      waddr_q     <= '0;
      reg_write_q <= 1'b0;
      wb_err_q    <= 1'b0;
      wb_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      waddr_q     <= waddr_d;
      reg_write_q <= reg_write_d;
      wb_err_q    <= wb_err_d;
      wb_ready_q  <= wb_ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    waddr_d  = waddr_q;
    wb_err_d = 1'b0;
    cnt_inc  = cnt_q + 4'd1;

    unique case (state_q)
      IDLE: begin
        sel_d = SEL_ALU;
        if (wb_valid && wb_ready_q) begin
          waddr_d = (wb_op == OP_JAL) ? LINK_REG : wb_rd;
          case (wb_op)
            OP_ALU: begin
              sel_d   = SEL_ALU;
              state_d = WRITE;
            end
            OP_LOAD: begin
              sel_d   = SEL_LOAD;
              cnt_d   = '0;
              state_d = WAIT_MEM;
            end
            OP_MFHI, OP_MFLO: begin
              sel_d   = (wb_op == OP_MFHI) ? SEL_MFHI : SEL_MFLO;
              state_d = hilo_busy ? WAIT_HILO : WRITE;
            end
            OP_JAL: begin
              sel_d   = SEL_JAL;
              state_d = WRITE;
            end
            default: wb_err_d = 1'b1;
          endcase
        end
      end
      WAIT_MEM: begin
        // Data arriving on the timeout cycle still completes the load.
        if (mem_valid) begin
          state_d = WRITE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            state_d  = IDLE;
            sel_d    = SEL_ALU;
            wb_err_d = 1'b1;
          end
        end
      end
      WAIT_HILO: begin
        if (!hilo_busy) state_d = WRITE;
      end
      WRITE: begin
        state_d = IDLE;
        sel_d   = SEL_ALU;
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_ALU;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    reg_write_d = (state_d == WRITE) && (waddr_d != '0);
    wb_ready_d  = (state_d == IDLE);
  end

  assign wb_ready     = wb_ready_q;
  assign sel_jump     = sel_q[2];
  assign sel_hilo     = sel_q[1];
  assign sel_memtoreg = sel_q[0];
  assign reg_write    = reg_write_q;
  assign reg_waddr    = waddr_q;
  assign wb_err       = wb_err_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Scoreboard bench for wb_sequencer: directed requests push the expected
// write/error event (cycle, address, selects); a negedge monitor pops and
// compares every reg_write or wb_err pulse the DUT produces.
module tb_wb_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wb_valid;
  logic       wb_ready;
  logic [2:0] wb_op;
  logic [4:0] wb_rd;
  logic       mem_valid;
  logic       hilo_busy;
  logic       sel_memtoreg;
  logic       sel_hilo;
  logic       sel_jump;
  logic       reg_write;
  logic [4:0] reg_waddr;
  logic       wb_err;

  typedef struct {
    bit         is_err;
    logic [4:0] waddr;
    logic [2:0] sel;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  wb_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_op        (wb_op),
    .wb_rd        (wb_rd),
    .mem_valid    (mem_valid),
    .hilo_busy    (hilo_busy),
    .sel_memtoreg (sel_memtoreg),
    .sel_hilo     (sel_hilo),
    .sel_jump     (sel_jump),
    .reg_write    (reg_write),
    .reg_waddr    (reg_waddr),
    .wb_err       (wb_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_err, input logic [4:0] waddr, input logic [2:0] sel,
                      input int at);
    exp_t e;
    e.is_err = is_err;
    e.waddr  = waddr;
    e.sel    = sel;
    e.cyc    = at;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for ready, then presents a request for this cycle.
  task automatic drive(input logic [2:0] op, input logic [4:0] rd, output int acc);
    for (int unsigned i = 0; i < 50 && !wb_ready; i++) next_cycle();
    check("ready_before_issue", 32'(wb_ready), 32'd1);
    wb_valid = 1'b1;
    wb_op    = op;
    wb_rd    = rd;
    acc      = cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(wb_ready), 32'd1);
    check({tag, "_sel"}, 32'({sel_jump, sel_hilo, sel_memtoreg}), 32'd0);
    check({tag, "_reg_write"}, 32'(reg_write), 32'd0);
    check({tag, "_waddr"}, 32'(reg_waddr), 32'd0);
    check({tag, "_err"}, 32'(wb_err), 32'd0);
  endtask

  // Monitor: every write or error pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (reg_write === 1'b1 || wb_err === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {25'd0, reg_waddr, reg_write, wb_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_kind", 32'({wb_err, reg_write}), e.is_err ? 32'd2 : 32'd1);
        check("event_cycle", 32'(cyc), 32'(e.cyc));
        check("event_sel", 32'({sel_jump, sel_hilo, sel_memtoreg}), 32'(e.sel));
        if (!e.is_err) check("event_waddr", 32'(reg_waddr), 32'(e.waddr));
      end
    end
  end

  initial begin
    int acc;
    wb_valid  = 1'b0;
    wb_op     = '0;
    wb_rd     = '0;
    mem_valid = 1'b0;
    hilo_busy = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (2) next_cycle();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    next_cycle();

    // ALU rd=5: write one cycle after acceptance, ready again the cycle after.
    drive(3'd0, 5'd5, acc);
    push(1'b0, 5'd5, 3'b000, acc + 1);
    next_cycle();
    wb_valid = 1'b0;
    check("alu_ready_in_write", 32'(wb_ready), 32'd0);
    next_cycle();
    check("alu_ready_after", 32'(wb_ready), 32'd1);

    // LOAD rd=8, mem_valid in acceptance cycle (ignored) and 3 cycles later.
    drive(3'd1, 5'd8, acc);
    mem_valid = 1'b1;
    push(1'b0, 5'd8, 3'b001, acc + 4);
    next_cycle();
    wb_valid  = 1'b0;
    mem_valid = 1'b0;
    check("load_sel_wait1", 32'({sel_jump, sel_hilo, sel_memtoreg}), 32'd1);
    check("load_ready_wait", 32'(wb_ready), 32'd0);
    next_cycle();
    check("load_sel_wait2", 32'({sel_jump, sel_hilo, sel_memtoreg}), 32'd1);
    next_cycle();
    mem_valid = 1'b1;
    next_cycle();
    mem_valid = 1'b0;
    next_cycle();

    // LOAD rd=9 with no data: error after 15 WAIT_MEM cycles.
    drive(3'd1, 5'd9, acc);
    push(1'b1, 5'd0, 3'b000, acc + 16);
    next_cycle();
    wb_valid = 1'b0;
    repeat (16) next_cycle();
    check("timeout_ready", 32'(wb_ready), 32'd1);

    // LOAD rd=10 with data on the timeout cycle: data wins.
    drive(3'd1, 5'd10, acc);
    push(1'b0, 5'd10, 3'b001, acc + 16);
    next_cycle();
    wb_valid = 1'b0;
    repeat (14) next_cycle();
    mem_valid = 1'b1;
    next_cycle();
    mem_valid = 1'b0;
    next_cycle();

    // MFLO rd=12 with hilo_busy high for 4 cycles.
    drive(3'd3, 5'd12, acc);
    hilo_busy = 1'b1;
    push(1'b0, 5'd12, 3'b011, acc + 5);
    next_cycle();
    wb_valid = 1'b0;
    check("mflo_sel_wait", 32'({sel_jump, sel_hilo, sel_memtoreg}), 32'd3);
    check("mflo_ready_wait", 32'(wb_ready), 32'd0);
    repeat (3) next_cycle();
    hilo_busy = 1'b0;
    repeat (2) next_cycle();

    // MFHI rd=7 with HI/LO idle: direct write.
    drive(3'd2, 5'd7, acc);
    push(1'b0, 5'd7, 3'b010, acc + 1);
    next_cycle();
    wb_valid = 1'b0;
    next_cycle();

    // JAL rd=3: link register 31, selects 100.
    drive(3'd4, 5'd3, acc);
    push(1'b0, 5'd31, 3'b100, acc + 1);
    next_cycle();
    wb_valid = 1'b0;
    next_cycle();

    // ALU rd=0: WRITE state without a write pulse.
    drive(3'd0, 5'd0, acc);
    next_cycle();
    wb_valid = 1'b0;
    check("rd0_no_write", 32'(reg_write), 32'd0);
    check("rd0_ready_in_write", 32'(wb_ready), 32'd0);
    next_cycle();
    check("rd0_ready_after", 32'(wb_ready), 32'd1);

    // Illegal op 6: error pulse, stays in IDLE.
    drive(3'd6, 5'd4, acc);
    push(1'b1, 5'd0, 3'b000, acc + 1);
    next_cycle();
    wb_valid = 1'b0;
    check("illegal_ready", 32'(wb_ready), 32'd1);
    next_cycle();

    // Reset during WAIT_MEM, then data arrives: no write.
    drive(3'd1, 5'd8, acc);
    next_cycle();
    wb_valid = 1'b0;
    next_cycle();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    next_cycle();
    rst_n     = 1'b1;
    mem_valid = 1'b1;
    repeat (2) next_cycle();
    mem_valid = 1'b0;
    repeat (3) next_cycle();
    check_reset_outputs("postreset");

    repeat (5) next_cycle();
    check("missing_responses", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, SHALL set the maximum number of WAIT_MEM cycles before a load is abandoned (range 1..15).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 wb_valid  input  1  decode presents a writeback request.
REQ-005 wb_ready  output  1  sequencer can accept a request (high only in IDLE).
REQ-006 wb_op  input  3  op class: 0 ALU, 1 LOAD, 2 MFHI, 3 MFLO, 4 JAL, 5-7 illegal.
REQ-007 wb_rd  input  5  destination register.
REQ-008 mem_valid  input  1  load data on dout is valid this cycle.
REQ-009 hilo_busy  input  1  multiply/divide unit still updating HI/LO.
REQ-010 sel_memtoreg, sel_hilo, sel_jump  output  1 each  writeback mux selects (SEL0/SEL1/SEL2).
REQ-011 reg_write  output  1  register-file write enable, one-cycle pulse.
REQ-012 reg_waddr  output  5  register-file write address.
REQ-013 wb_err  output  1  one-cycle pulse on illegal op or load timeout.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, WAIT_MEM, WAIT_HILO and WRITE; all outputs SHALL be registered.
REQ-015 A request SHALL be accepted only on a cycle where wb_valid and wb_ready are both high; wb_op and wb_rd SHALL be captured on that cycle.
REQ-016 On acceptance the selects SHALL load per op: ALU 000, LOAD 001, MFHI 010, MFLO 011, JAL 100 ({sel_jump,sel_hilo,sel_memtoreg}); the selects SHALL hold until the return to IDLE and SHALL read 000 in IDLE.
REQ-017 reg_waddr SHALL be 31 for JAL and the captured wb_rd otherwise.
REQ-018 ALU/JAL: IDLE->WRITE; reg_write high in the cycle after acceptance (latency 1).
REQ-019 LOAD: IDLE->WAIT_MEM; the first mem_valid seen in WAIT_MEM SHALL cause ->WRITE, so reg_write asserts one cycle after that mem_valid.
REQ-020 mem_valid asserted in IDLE or in the acceptance cycle SHALL be ignored.
REQ-021 A 4-bit wait counter SHALL clear on entry to WAIT_MEM and increment each WAIT_MEM cycle without mem_valid; on reaching MEM_TIMEOUT the FSM SHALL go to IDLE with a wb_err pulse and no reg_write.
REQ-022 mem_valid in the same cycle the counter reaches MEM_TIMEOUT SHALL win (->WRITE, no error).
REQ-023 MFHI/MFLO: if hilo_busy is low at acceptance, ->WRITE; otherwise ->WAIT_HILO, leaving on the first cycle hilo_busy is low to ->WRITE (no timeout).
REQ-024 WRITE SHALL last exactly one cycle, then ->IDLE; reg_write SHALL be high only in WRITE.
REQ-025 If the target address is 0, WRITE SHALL still occur as a state but reg_write SHALL stay low.
REQ-026 An illegal op SHALL be accepted, produce a wb_err pulse the next cycle, and leave the FSM in IDLE with no write.
REQ-027 wb_ready SHALL be low in all states except IDLE, so back-to-back requests are accepted at most every 2 cycles.

Reset
REQ-028 While rst_n is low: state IDLE, wb_ready 1, selects 000, reg_write 0, reg_waddr 0, wb_err 0, counter 0.
REQ-029 Reset asserted mid-operation (any state) SHALL abort the pending write with no reg_write pulse after release.

Structure
REQ-030 Shared package wb_pkg SHALL hold the op encodings, the state enumeration, the 3-bit select constants and the JAL link register index 31.
REQ-031 There SHALL be no sub-module; the timeout counter SHALL live inline.

Verification
REQ-032 ALU op, rd=5, accepted at cycle 0 -> reg_write=1, reg_waddr=5 and selects 000 at cycle 1; wb_ready=1 at cycle 2.
REQ-033 LOAD rd=8, mem_valid 3 cycles after acceptance -> selects 001 throughout, single reg_write pulse one cycle after mem_valid.
REQ-034 LOAD with mem_valid never asserted, MEM_TIMEOUT=15 -> wb_err pulse after 15 WAIT_MEM cycles, no reg_write, back in IDLE.
REQ-035 MFLO with hilo_busy high 4 cycles -> WAIT_HILO for 4 cycles, then a reg_write with selects 011.
REQ-036 JAL with wb_rd=3 -> reg_waddr=31 and selects 100; ALU with rd=0 -> no reg_write.
REQ-037 rst_n pulsed low during WAIT_MEM, then mem_valid -> no reg_write, all outputs at reset values, wb_ready=1.
